// File: rtl/negate_scheduler_pkg.sv
// Shared definitions for the negate scheduler: FSM states, mode encodings and
// the overflow rule for two's-complement negation.
package negate_scheduler_pkg;

    localparam int W_NEG = 16;

    localparam logic MODE_ONES = 1'b0;
    localparam logic MODE_TWOS = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INVERT = 2'd1,
        ST_INCR   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Only the most negative value has no positive counterpart.
    function automatic logic is_twos_overflow(input logic i_mode, input logic [W_NEG-1:0] i_op);
        return (i_mode == MODE_TWOS) && (i_op == {1'b1, {(W_NEG-1){1'b0}}});
    endfunction

endpackage

// File: rtl/negate_scheduler_rr_arbiter.sv
// Round-robin picker: grants the first asserted request at or after the pointer.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_valid,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_index
);

    int            w_pos;
    logic [IW-1:0] w_idx;

    // Scanning from the far end lets the closest request to the pointer win last.
    always_comb begin
        o_valid = 1'b0;
        o_grant = '0;
        o_index = '0;
        w_pos   = 0;
        w_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            w_idx = w_pos[IW-1:0];
            if (i_req[w_idx]) begin
                o_valid        = 1'b1;
                o_grant        = '0;
                o_grant[w_idx] = 1'b1;
                o_index        = w_idx;
            end
        end
    end

endmodule

// File: rtl/sixteen_bit_negator.sv
// Shared 16-bit bitwise negator datapath; purely combinational.
module sixteen_bit_negator (
    input  logic [15:0] i_data,
    output logic [15:0] o_data
);

    assign o_data = ~i_data;

endmodule

// File: rtl/negate_scheduler.sv
// Round-robin scheduler sharing one 16-bit negator between N requesters,
// supporting one's-complement and two's-complement (invert then increment).
//
// state  | meaning
// IDLE   | arbitrate; latch grant, operand and mode of the winner
// INVERT | invert latched operand through the shared negator
// INCR   | add one to the inverted value (two's complement only)
// DONE   | ack pulses for the granted requester, advance round-robin pointer
module negate_scheduler
    import negate_scheduler_pkg::*;
#(
    parameter int N = 4,
    parameter int W = W_NEG
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   mode,
    input  logic [N*W-1:0] operand,
    output logic [N-1:0]   ack,
    output logic [W-1:0]   result,
    output logic           overflow,
    output logic           busy
);

    localparam int IW = $clog2(N);

    state_t        r_state;
    logic [IW-1:0] r_rr_ptr;
    logic [IW-1:0] r_grant_idx;
    logic [N-1:0]  r_grant_oh;
    logic [W-1:0]  r_op;
    logic          r_mode;
    logic [W-1:0]  r_acc;
    logic [N-1:0]  r_ack;
    logic [W-1:0]  r_result;
    logic          r_overflow;
    logic          r_busy;

    logic          w_arb_valid;
    logic [N-1:0]  w_arb_grant;
    logic [IW-1:0] w_arb_index;
    logic [W-1:0]  w_sel_op;
    logic [W-1:0]  w_neg;
    logic [W-1:0]  w_inc;

    rr_arbiter #(
        .N  (N),
        .IW (IW)
    ) u_arbiter (
        .i_req   (req),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_arb_valid),
        .o_grant (w_arb_grant),
        .o_index (w_arb_index)
    );

    sixteen_bit_negator u_negator (
        .i_data (r_op),
        .o_data (w_neg)
    );

    assign w_sel_op = operand[w_arb_index*W +: W];
    assign w_inc    = r_acc + W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_grant_oh  <= '0;
            r_op        <= '0;
            r_mode      <= MODE_ONES;
            r_acc       <= '0;
            r_ack       <= '0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_valid) begin
                        r_grant_idx <= w_arb_index;
                        r_grant_oh  <= w_arb_grant;
                        r_op        <= w_sel_op;
                        r_mode      <= mode[w_arb_index];
                        r_state     <= ST_INVERT;
                        r_busy      <= 1'b1;
                    end
                end
                ST_INVERT: begin
                    r_acc <= w_neg;
                    if (r_mode == MODE_TWOS) begin
                        r_state <= ST_INCR;
                    end else begin
                        r_state    <= ST_DONE;
                        r_ack      <= r_grant_oh;
                        r_result   <= w_neg;
                        r_overflow <= 1'b0;
                    end
                end
                ST_INCR: begin
                    r_acc      <= w_inc;
                    r_state    <= ST_DONE;
                    r_ack      <= r_grant_oh;
                    r_result   <= w_inc;
                    r_overflow <= is_twos_overflow(r_mode, r_op);
                end
                ST_DONE: begin
                    r_rr_ptr <= (r_grant_idx == IW'(N - 1)) ? '0 : r_grant_idx + IW'(1);
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ack      = r_ack;
    assign result   = r_result;
    assign overflow = r_overflow;
    assign busy     = r_busy;

endmodule

// File: tb/tb_negate_scheduler.sv
// Self-checking bench for negate_scheduler: directed scenarios plus randomized
// traffic compared against an arithmetic reference model.
module tb_negate_scheduler;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N-1:0]   mode;
    logic [N*W-1:0] operand;
    logic [N-1:0]   ack;
    logic [W-1:0]   result;
    logic           overflow;
    logic           busy;

    int errors = 0;
    int checks = 0;
    int mptr   = 0;

    negate_scheduler #(.N(N), .W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .mode     (mode),
        .operand  (operand),
        .ack      (ack),
        .result   (result),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Negation computed as subtraction from 2^16 (two's) or from 2^16-1 (one's).
    function automatic logic [15:0] ref_result(input logic m, input logic [15:0] op);
        logic [16:0] t;
        if (m) t = 17'h10000 - {1'b0, op};
        else   t = 17'h0FFFF - {1'b0, op};
        return t[15:0];
    endfunction

    function automatic logic ref_ovf(input logic m, input logic [15:0] op);
        return m && (op != 16'h0000) && (ref_result(m, op) == op);
    endfunction

    function automatic int ref_grant(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [15:0] pick_op();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'hFFFF;
            3: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic set_op(input int i, input logic m, input logic [15:0] op);
        mode[i] = m;
        operand[i*W +: W] = op;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = '0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        mptr = 0;
    endtask

    // Called at the negedge of an IDLE cycle with req already driven; returns at
    // the negedge of the ack cycle. Optionally scrambles the winner's inputs after grant.
    task automatic run_op(input string name, input bit scramble, output int g);
        logic [N-1:0] exp_ack;
        logic [15:0]  eop;
        logic         em;
        int           lat;
        int           n;
        g = ref_grant(req, mptr);
        if (g < 0) begin
            errors++;
            checks++;
            $display("FAIL %s grant: no request driven, req=%b", name, req);
            g = 0;
            return;
        end
        em  = mode[g];
        eop = operand[g*W +: W];
        lat = em ? 3 : 2;
        exp_ack = '0;
        exp_ack[g] = 1'b1;
        n = 0;
        do begin
            next_cycle();
            n++;
            if (scramble && n == 1) begin
                operand[g*W +: W] = ~eop ^ 16'h5A5A;
                mode[g] = ~em;
            end
        end while (ack == '0 && n < 8);
        checks++;
        if (ack !== exp_ack) begin
            errors++;
            $display("FAIL %s ack: got %b expected %b", name, ack, exp_ack);
        end
        checks++;
        if (n != lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, n, lat);
        end
        checks++;
        if (result !== ref_result(em, eop)) begin
            errors++;
            $display("FAIL %s result: got %h expected %h (op %h mode %0d)", name, result, ref_result(em, eop), eop, em);
        end
        checks++;
        if (overflow !== ref_ovf(em, eop)) begin
            errors++;
            $display("FAIL %s overflow: got %b expected %b", name, overflow, ref_ovf(em, eop));
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_in_done: got %b expected 1", name, busy);
        end
        mptr = (g + 1) % N;
    endtask

    task automatic test_reset();
        req = '0;
        mode = '0;
        operand = '0;
        rst_n = 1'b0;
        #12;
        checks++;
        if (ack !== '0 || result !== 16'h0000 || overflow !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: got ack=%b result=%h ovf=%b busy=%b expected all zero", ack, result, overflow, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mptr = 0;
        next_cycle();
        checks++;
        if (busy !== 1'b0 || ack !== '0) begin
            errors++;
            $display("FAIL idle_no_req: got busy=%b ack=%b expected 0", busy, ack);
        end
    endtask

    task automatic test_ones();
        int g;
        set_op(0, 1'b0, 16'h00FF);
        req = 4'b0001;
        run_op("ones_00FF", 1'b0, g);
        req[g] = 1'b0;
        next_cycle();
    endtask

    task automatic test_twos();
        int g;
        set_op(1, 1'b1, 16'h0005);
        req = 4'b0010;
        run_op("twos_0005", 1'b1, g);
        req[g] = 1'b0;
        next_cycle();
        set_op(1, 1'b1, 16'h8000);
        req = 4'b0010;
        run_op("twos_8000", 1'b0, g);
        req[g] = 1'b0;
        next_cycle();
    endtask

    task automatic test_back_to_back();
        int  g;
        time t_prev;
        pulse_reset();
        for (int i = 0; i < N; i++) set_op(i, 1'b0, 16'($urandom));
        req = 4'b1111;
        t_prev = 0;
        for (int i = 0; i < N; i++) begin
            run_op("b2b", 1'b0, g);
            if (i > 0) begin
                checks++;
                if ($time - t_prev != 30) begin
                    errors++;
                    $display("FAIL b2b spacing: got %0t expected 30", $time - t_prev);
                end
            end
            t_prev = $time;
            req[g] = 1'b0;
            next_cycle();
        end
    endtask

    task automatic test_edges();
        int g;
        set_op(2, 1'b1, 16'h0000);
        req = 4'b0100;
        run_op("twos_0000", 1'b0, g);
        req[g] = 1'b0;
        next_cycle();
        set_op(3, 1'b0, 16'hFFFF);
        req = 4'b1000;
        run_op("ones_FFFF", 1'b0, g);
        req[g] = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_mid_op();
        int g;
        set_op(0, 1'b0, 16'h1234);
        req = 4'b0001;
        run_op("pre_reset", 1'b0, g);
        req[g] = 1'b0;
        next_cycle();
        set_op(2, 1'b1, 16'h0042);
        req = 4'b0100;
        next_cycle();
        next_cycle();
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || result !== 16'h0000 || ack !== '0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_op: got busy=%b result=%h ack=%b ovf=%b expected 0", busy, result, ack, overflow);
        end
        req = '0;
        next_cycle();
        next_cycle();
        checks++;
        if (ack !== '0) begin
            errors++;
            $display("FAIL reset_mid_op ack: got %b expected 0", ack);
        end
        rst_n = 1'b1;
        mptr = 0;
        next_cycle();
        set_op(0, 1'b0, 16'hA5A5);
        req = 4'b0101;
        run_op("post_reset_ptr", 1'b0, g);
        req[g] = 1'b0;
        next_cycle();
        run_op("post_reset_req2", 1'b0, g);
        req[g] = 1'b0;
        next_cycle();
    endtask

    task automatic test_drop_req();
        logic [15:0] eop;
        eop = 16'h3C3C;
        set_op(3, 1'b0, eop);
        req = 4'b1000;
        next_cycle();
        req[3] = 1'b0;
        next_cycle();
        checks++;
        if (ack !== 4'b1000 || result !== ref_result(1'b0, eop)) begin
            errors++;
            $display("FAIL drop_req: got ack=%b result=%h expected ack=1000 result=%h", ack, result, ref_result(1'b0, eop));
        end
        mptr = 0;
        next_cycle();
        checks++;
        if (busy !== 1'b0 || ack !== '0) begin
            errors++;
            $display("FAIL drop_req idle: got busy=%b ack=%b expected 0", busy, ack);
        end
        next_cycle();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_req stays_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_random();
        int           g;
        logic [N-1:0] nb;
        req = '0;
        for (int it = 0; it < 60; it++) begin
            if (req == '0) begin
                nb = N'($urandom_range(1, (1 << N) - 1));
            end else begin
                nb = N'($urandom) & ~req;
            end
            for (int i = 0; i < N; i++) begin
                if (nb[i]) set_op(i, 1'($urandom), pick_op());
            end
            req = req | nb;
            run_op("random", 1'($urandom), g);
            req[g] = 1'b0;
            next_cycle();
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_ones();
        test_twos();
        test_back_to_back();
        test_edges();
        test_reset_mid_op();
        test_drop_req();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
